// File: rtl/sim_ctrl_pkg.sv
// Shared constants for the simulation run controller: default parameters
// and the FSM state encoding.
package sim_ctrl_pkg;

  localparam int DEF_RESET_CYCLES = 5;
  localparam int DEF_MAX_CYCLES   = 3250;
  localparam int DEF_HALT_REPEAT  = 3;
  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_PC_W         = 32;
  localparam int DEF_CNT_W        = 32;

  localparam logic [2:0] ST_HOLD    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_DRAIN   = 3'd2;
  localparam logic [2:0] ST_HALTED  = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pc_repeat_det.sv
// Halt detector: flags the commit that makes HALT_REPEAT consecutive
// retirements at the same PC.
module pc_repeat_det #(
  parameter int PC_W        = 32,
  parameter int HALT_REPEAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            commit_valid_i,
  input  logic [PC_W-1:0] commit_pc_i,
  output logic            hit_o
);

  localparam int RW = $clog2(HALT_REPEAT + 1);

  logic [PC_W-1:0] last_pc_q;
  logic [RW-1:0]   rep_q, rep_d;

  // Saturate so a stalled FSM can never wrap the count back below threshold.
  always_comb begin
    rep_d = RW'(1);
    if (commit_pc_i == last_pc_q)
      rep_d = (rep_q == RW'(HALT_REPEAT)) ? rep_q : rep_q + RW'(1);
  end

  assign hit_o = en_i && commit_valid_i && (rep_d == RW'(HALT_REPEAT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_pc_q <= '0;
      rep_q     <= '0;
    end else if (clr_i) begin
      last_pc_q <= '0;
      rep_q     <= '0;
    end else if (en_i && commit_valid_i) begin
      last_pc_q <= commit_pc_i;
      rep_q     <= rep_d;
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller for a CPU under simulation: reset sequencing, halt/timeout
// detection, cycle and retirement counters. RESET_CYCLES must be at least 1.
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int HALT_REPEAT  = DEF_HALT_REPEAT,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int PC_W         = DEF_PC_W,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rerun,
  input  logic             commit_valid,
  input  logic [PC_W-1:0]  commit_pc,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] commit_cnt
);

  // One phase counter serves both the HOLD and DRAIN sequences.
  localparam int PH_W = $clog2(max2(RESET_CYCLES, DRAIN_CYCLES) + 2);

  logic [2:0]       state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, com_q, com_d, cyc_inc;
  logic             det_en, det_clr, det_hit;
  logic             cpu_reset_q, running_q, done_q, halted_q, timed_out_q;

  assign det_en = (state_q == ST_RUN);

  pc_repeat_det #(
    .PC_W        (PC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_det (
    .clk            (clk),
    .reset          (reset),
    .clr_i          (det_clr),
    .en_i           (det_en),
    .commit_valid_i (commit_valid),
    .commit_pc_i    (commit_pc),
    .hit_o          (det_hit)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cyc_d   = cyc_q;
    com_d   = com_q;
    det_clr = 1'b0;
    cyc_inc = cyc_q + CNT_W'(1);

    if (state_q == ST_RUN || state_q == ST_DRAIN) begin
      cyc_d = cyc_inc;
      if (commit_valid && !(&com_q)) com_d = com_q + CNT_W'(1);
    end

    case (state_q)
      ST_HOLD: begin
        if (ph_q == PH_W'(RESET_CYCLES - 1)) begin
          state_d = ST_RUN;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      // Halt takes priority over a timeout landing on the same edge.
      ST_RUN: begin
        if (det_hit) begin
          state_d = (DRAIN_CYCLES == 0) ? ST_HALTED : ST_DRAIN;
          ph_d    = '0;
        end else if (cyc_inc == CNT_W'(MAX_CYCLES)) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        if (ph_q == PH_W'(DRAIN_CYCLES - 1)) state_d = ST_HALTED;
        else                                 ph_d    = ph_q + PH_W'(1);
      end
      ST_HALTED, ST_TIMEOUT: begin
        if (rerun) begin
          state_d = ST_HOLD;
          ph_d    = '0;
          cyc_d   = '0;
          com_d   = '0;
          det_clr = 1'b1;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      ph_q        <= '0;
      cyc_q       <= '0;
      com_q       <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cyc_q       <= cyc_d;
      com_q       <= com_d;
      cpu_reset_q <= (state_d == ST_HOLD);
      running_q   <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q      <= (state_d == ST_HALTED) || (state_d == ST_TIMEOUT);
      halted_q    <= (state_d == ST_HALTED);
      timed_out_q <= (state_d == ST_TIMEOUT);
    end
  end

  assign cpu_reset  = cpu_reset_q;
  assign running    = running_q;
  assign done       = done_q;
  assign halted     = halted_q;
  assign timed_out  = timed_out_q;
  assign cycle_cnt  = cyc_q;
  assign commit_cnt = com_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: a run-level model predicts how each run
// ends; a monitor checks the outcome whenever done rises.
module tb_sim_run_ctrl;

  localparam int NS   = 3300;
  localparam int MAXC = 3250;
  localparam int HREP = 3;
  localparam int DRN  = 4;

  typedef struct {
    bit halt;
    bit tout;
    int cyc;
    int com;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, rerun, commit_valid;
  logic [31:0] commit_pc;
  logic        cpu_reset, running, done, halted, timed_out;
  logic [31:0] cycle_cnt, commit_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  logic done_prev = 1'b0;

  bit          stv[NS];
  logic [31:0] stp[NS];
  bit          str[NS];

  sim_run_ctrl #(
    .RESET_CYCLES (5),
    .MAX_CYCLES   (MAXC),
    .HALT_REPEAT  (HREP),
    .DRAIN_CYCLES (DRN),
    .PC_W         (32),
    .CNT_W        (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rerun        (rerun),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .cpu_reset    (cpu_reset),
    .running      (running),
    .done         (done),
    .halted       (halted),
    .timed_out    (timed_out),
    .cycle_cnt    (cycle_cnt),
    .commit_cnt   (commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Run outcome from the rules: halt once the last HREP RUN-phase commits
  // share one PC (then DRN drain cycles), else time out at MAXC cycles.
  function automatic exp_t model();
    exp_t r;
    logic [31:0] pcs[$];
    int com = 0;
    bit same;
    r = '{0, 0, 0, 0};
    for (int k = 1; k < NS - DRN; k++) begin
      if (stv[k]) begin
        com++;
        pcs.push_back(stp[k]);
        if (pcs.size() >= HREP) begin
          same = 1'b1;
          for (int j = 1; j < HREP; j++)
            if (pcs[pcs.size()-1-j] != pcs[pcs.size()-1]) same = 1'b0;
          if (same) begin
            for (int d = 1; d <= DRN; d++) if (stv[k+d]) com++;
            r.halt = 1'b1; r.cyc = k + DRN; r.com = com;
            return r;
          end
        end
      end
      if (k == MAXC) begin
        r.tout = 1'b1; r.cyc = k; r.com = com;
        return r;
      end
    end
    return r;
  endfunction

  // Monitor: each rising done retires one expected outcome.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_halted", halted, e.halt);
          chk("sb_timed_out", timed_out, e.tout);
          chk("sb_cycle_cnt", cycle_cnt, e.cyc);
          chk("sb_commit_cnt", commit_cnt, e.com);
          chk("sb_running", running, 1'b0);
        end
      end
      done_prev = done;
    end
  end

  task automatic stim_clear();
    for (int k = 0; k < NS; k++) begin
      stv[k] = 1'b0; stp[k] = '0; str[k] = 1'b0;
    end
  endtask

  task automatic stim_halt5();
    stim_clear();
    stv[1] = 1; stp[1] = 32'h3000;
    stv[2] = 1; stp[2] = 32'h3004;
    stv[3] = 1; stp[3] = 32'h3008;
    stv[4] = 1; stp[4] = 32'h3008;
    stv[5] = 1; stp[5] = 32'h3008;
  endtask

  task automatic stim_distinct();
    stim_clear();
    for (int k = 1; k < NS; k++) begin
      stv[k] = 1'b1; stp[k] = 32'(k) * 4;
    end
  endtask

  task automatic stim_rand(input int mode);
    stim_clear();
    for (int k = 1; k < NS; k++) begin
      stv[k] = (mode == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
      stp[k] = (mode == 0) ? 32'h100 + 4 * $urandom_range(0, 1)
                           : 32'h200 + 4 * $urandom_range(0, 3);
      str[k] = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic do_rerun();
    @(negedge clk);
    rerun = 1'b1;
    @(posedge clk); #1;
    rerun = 1'b0;
    chk("rerun_cpu_reset", cpu_reset, 1'b1);
    chk("rerun_cycle_cnt", cycle_cnt, 0);
    chk("rerun_commit_cnt", commit_cnt, 0);
    chk("rerun_done", done, 1'b0);
    chk("rerun_flags", {halted, timed_out, running}, 3'b000);
  endtask

  // Drives one run from the start of HOLD; abort_at>0 pulses reset after
  // that RUN cycle instead of letting the run finish.
  task automatic drive_run(input int abort_at, input exp_t e);
    bit fin = 1'b0;
    int ncom = 0;
    for (int i = 1; i <= 5; i++) begin
      commit_valid = 1'b1; commit_pc = 32'h3008;
      @(posedge clk); #1;
      chk("hold_cpu_reset", cpu_reset, (i < 5));
      chk("hold_running", running, (i == 5));
    end
    for (int k = 1; k < NS && !fin; k++) begin
      commit_valid = stv[k]; commit_pc = stp[k]; rerun = str[k];
      if (stv[k]) ncom++;
      @(posedge clk); #1;
      rerun = 1'b0;
      if (k == 1) chk("first_run_cycle", cycle_cnt, 1);
      if (k == abort_at) begin
        chk("pre_abort_cycle", cycle_cnt, k);
        chk("pre_abort_commit", commit_cnt, ncom);
        #1 reset = 1'b1;
        #1;
        chk("abort_cpu_reset", cpu_reset, 1'b1);
        chk("abort_cycle_cnt", cycle_cnt, 0);
        chk("abort_commit_cnt", commit_cnt, 0);
        chk("abort_flags", {running, done, halted, timed_out}, 4'b0000);
        @(negedge clk);
        reset = 1'b0; commit_valid = 1'b0;
        return;
      end
      if (done === 1'b1) fin = 1'b1;
    end
    commit_valid = 1'b0;
    if (!fin) begin
      chk("run_ended", done, 1'b1);
      return;
    end
    for (int i = 0; i < 3; i++) begin
      commit_valid = 1'b1; commit_pc = $urandom;
      @(posedge clk); #1;
    end
    commit_valid = 1'b0;
    chk("frozen_cycle_cnt", cycle_cnt, e.cyc);
    chk("frozen_commit_cnt", commit_cnt, e.com);
    chk("frozen_done", done, 1'b1);
    chk("frozen_one_flag", {halted, timed_out}, {e.halt, e.tout});
  endtask

  task automatic run_test(input int abort_at);
    exp_t e;
    e = model();
    if (abort_at == 0) exp_q.push_back(e);
    drive_run(abort_at, e);
  endtask

  initial begin
    reset = 1'b1; rerun = 1'b0; commit_valid = 1'b0; commit_pc = '0;
    #3;
    chk("rst_cpu_reset", cpu_reset, 1'b1);
    chk("rst_running", running, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_timed_out", timed_out, 1'b0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_commit_cnt", commit_cnt, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    stim_halt5();
    run_test(0);

    do_rerun();
    stim_halt5();
    str[2] = 1'b1;
    run_test(0);

    do_rerun();
    stim_distinct();
    run_test(0);

    do_rerun();
    stim_distinct();
    for (int k = 3248; k <= 3250; k++) stp[k] = 32'hFFFF_0000;
    for (int k = 3251; k < NS; k++) stv[k] = 1'b0;
    run_test(0);

    for (int t = 0; t < 6; t++) begin
      do_rerun();
      stim_rand(t % 2);
      run_test(0);
    end

    do_rerun();
    stim_distinct();
    run_test(100);
    stim_halt5();
    run_test(0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_run_ctrl.md
SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- RESET_CYCLES, 5: cycles cpu_reset is held after leaving reset.
- MAX_CYCLES, 3250: RUN-cycle budget before timeout.
- HALT_REPEAT, 3: consecutive commits at the same PC that declare halt; must be 2 or more.
- DRAIN_CYCLES, 4: cycles allowed after halt detection for the pipeline to drain.
- PC_W, 32: commit PC width.
- CNT_W, 32: counter width; MAX_CYCLES must fit in CNT_W.

REQ-002 Ports SHALL be, one per line:
- clk, in, 1: single clock; all state on rising edge.
- reset, in, 1: asynchronous, active-high.
- rerun, in, 1: single-cycle pulse requesting a fresh run.
- commit_valid, in, 1: the CPU retired one instruction this cycle.
- commit_pc, in, PC_W: PC of the retired instruction.
- cpu_reset, out, 1: registered reset to the CPU under test.
- running, out, 1: high in RUN or DRAIN.
- done, out, 1: high in HALTED or TIMEOUT.
- halted, out, 1: run ended by halt detection.
- timed_out, out, 1: run ended by cycle budget.
- cycle_cnt, out, CNT_W: RUN plus DRAIN cycles elapsed.
- commit_cnt, out, CNT_W: retired instructions.

Function
REQ-003 The FSM SHALL have exactly five states: HOLD, RUN, DRAIN, HALTED, TIMEOUT.
REQ-004 HOLD SHALL assert cpu_reset for exactly RESET_CYCLES rising edges, then enter RUN with cpu_reset low on the next cycle.
REQ-005 In RUN and DRAIN, cycle_cnt SHALL increment once per cycle.
REQ-006 In RUN and DRAIN, commit_cnt SHALL increment on each commit_valid and saturate at all-ones.
REQ-007 Halt detector behaviour:
- On commit_valid, repeat count := repeat+1 if commit_pc equals the last committed PC, else 1.
- The last committed PC updates on every commit_valid.
- commit_valid outside RUN SHALL be ignored by the detector.
REQ-008 When repeat count reaches HALT_REPEAT in RUN, the FSM SHALL enter DRAIN on that edge.
REQ-009 DRAIN SHALL last DRAIN_CYCLES cycles, then enter HALTED; with DRAIN_CYCLES=0, HALTED SHALL be entered directly in place of DRAIN.
REQ-010 In RUN, when cycle_cnt would reach MAX_CYCLES, the FSM SHALL enter TIMEOUT.
REQ-011 If halt detection and timeout occur on the same edge, halt SHALL win (DRAIN). Timeout SHALL NOT be checked in DRAIN.
REQ-012 HALTED and TIMEOUT SHALL be terminal states: counters frozen, done=1, and exactly one of halted/timed_out high.
REQ-013 rerun in HALTED or TIMEOUT SHALL, on the next edge:
- enter HOLD;
- clear both counters, the detector state and the flags;
- assert cpu_reset.
REQ-014 rerun SHALL be ignored in HOLD, RUN and DRAIN.
REQ-015 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-016 reset high SHALL immediately force:
- state HOLD, hold counter 0, cpu_reset=1;
- running, done, halted and timed_out all 0;
- both counters 0, repeat count 0, last PC 0.
REQ-017 reset asserted mid-run SHALL abort the run with no terminal flag set, then restart the HOLD sequence on release.

Structure
REQ-018 A shared package sim_ctrl_pkg SHALL hold the state encoding and the default parameter constants.
REQ-019 Halt detection SHALL be a sub-module pc_repeat_det containing the last-PC register, the repeat counter and the hit output.

Verification
Settings: RESET_CYCLES=5, MAX_CYCLES=3250, HALT_REPEAT=3, DRAIN_CYCLES=4.
REQ-020 Release reset -> cpu_reset high for exactly 5 edges, then running=1 and cycle_cnt=1 after the first RUN edge.
REQ-021 Commit PCs 0x3000, 0x3004, 0x3008, 0x3008, 0x3008 -> DRAIN on the 5th commit, then after 4 drain cycles with no commits: halted=1, done=1, commit_cnt=5.
REQ-022 Distinct PCs committed every cycle -> timed_out=1 with cycle_cnt=3250 and halted=0.
REQ-023 Third repeat lands on the edge where cycle_cnt would reach 3250 -> DRAIN, then halted=1 and timed_out=0.
REQ-024 reset pulsed at RUN cycle 100 -> cpu_reset=1 and both counters 0 without waiting for clk; a fresh 5-cycle HOLD follows.
REQ-025 Two rerun cases:
- rerun during RUN -> no effect.
- rerun in HALTED -> HOLD next edge, counters 0, flags clear, and a second halt run gives identical counts.
